// File: rtl/tcp_conn_ctrl.sv
// tcp_conn_ctrl
// Connection controller for a minimal stop-and-wait TCP sender. It opens a
// connection with SYN, sends data segments one at a time, acknowledges
// received payload (delayed or piggy-backed), closes with FIN and aborts
// with RST after repeated retransmit timeouts.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   open_req, close_req      single-cycle connection open / close requests
//   app_tx_valid/ready       application data-segment handshake
//   rx_seg_valid, rx_flags,  received segment strobe, flags, ack number
//   rx_ack_num
//   seg_tx_valid/ready,      outgoing segment request to the segment builder
//   seg_tx_flags, seg_tx_seq
//   state_o, conn_up         connection state, established indicator
//   conn_err                 one-cycle pulse on abort (peer RST or give-up)
//   rx_deliver               one-cycle pulse per received payload segment
//
// State table
//   state       | meaning
//   CLOSED      | idle, waiting for open_req
//   SYN_SENT    | SYN outstanding, waiting for SYN|ACK
//   ESTABLISHED | data transfer, delayed ACK, close latch
//   FIN_WAIT    | FIN|ACK outstanding, waiting for its ACK
module tcp_conn_ctrl #(
   parameter int PAYLOAD_LEN      = 262,
   parameter int SEQ_W            = 32,
   parameter int ISN              = 0,
   parameter int DELAY_ACK_CYCLES = 1000000,
   parameter int RTO_CYCLES       = 4000000,
   parameter int MAX_RETRY        = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             open_req,
   input  logic             close_req,
   input  logic             app_tx_valid,
   output logic             app_tx_ready,
   input  logic             rx_seg_valid,
   input  logic [5:0]       rx_flags,
   input  logic [SEQ_W-1:0] rx_ack_num,
   output logic             seg_tx_valid,
   input  logic             seg_tx_ready,
   output logic [5:0]       seg_tx_flags,
   output logic [SEQ_W-1:0] seg_tx_seq,
   output logic [1:0]       state_o,
   output logic             conn_up,
   output logic             conn_err,
   output logic             rx_deliver
);

   localparam logic [5:0] FL_FIN = 6'h01;
   localparam logic [5:0] FL_SYN = 6'h02;
   localparam logic [5:0] FL_RST = 6'h04;
   localparam logic [5:0] FL_PSH = 6'h08;
   localparam logic [5:0] FL_ACK = 6'h10;

   localparam int DW = (DELAY_ACK_CYCLES < 1) ? 1 : $clog2(DELAY_ACK_CYCLES + 1);
   localparam int TW = (RTO_CYCLES < 1) ? 1 : $clog2(RTO_CYCLES + 1);
   localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

   localparam logic [DW-1:0] DACK_MAX  = DW'(DELAY_ACK_CYCLES);
   localparam logic [DW-1:0] DACK_LAST = DW'(DELAY_ACK_CYCLES - 1);
   localparam logic [TW-1:0] RTO_MAX   = TW'(RTO_CYCLES);
   localparam logic [TW-1:0] RTO_LAST  = TW'(RTO_CYCLES - 1);
   localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

   typedef enum logic [1:0] {
      CLOSED      = 2'd0,
      SYN_SENT    = 2'd1,
      ESTABLISHED = 2'd2,
      FIN_WAIT    = 2'd3
   } state_t;

   typedef enum logic [3:0] {
      A_NONE, A_ABORT, A_OPEN, A_EST, A_RETX, A_GIVEUP,
      A_DATA, A_FIN, A_ACK, A_FIN_DONE
   } act_t;

   state_t           state;
   logic [SEQ_W-1:0] snd_nxt;
   logic             outstanding;
   logic [5:0]       last_flags;
   logic [SEQ_W-1:0] last_seq;
   logic [TW-1:0]    rto_cnt;
   logic [RW-1:0]    retry;
   logic             need_ack;
   logic [DW-1:0]    dack_cnt;
   logic             ack_req;
   logic             close_lat;

   logic rx_rst, rx_ack_ok, rx_synack, rx_psh;
   logic free, rto_due, dack_due, app_accept;
   logic [5:0] data_flags;
   act_t act, to_act;

   // FIN and URG on received segments carry no meaning for this controller.
   logic unused_rx_flags;
   assign unused_rx_flags = rx_flags[0] ^ rx_flags[5];

   assign state_o      = state;
   assign conn_up      = (state == ESTABLISHED);
   assign app_tx_ready = (state == ESTABLISHED) && !outstanding && !seg_tx_valid && !close_lat;

   always_comb begin
      rx_rst     = rx_seg_valid && rx_flags[2];
      rx_ack_ok  = rx_seg_valid && rx_flags[4] && (rx_ack_num == snd_nxt);
      rx_synack  = rx_ack_ok && rx_flags[1];
      rx_psh     = rx_seg_valid && rx_flags[3] && (state == ESTABLISHED);
      // the request slot is free if empty or being handed off this cycle
      free       = !seg_tx_valid || seg_tx_ready;
      rto_due    = outstanding && (rto_cnt >= RTO_LAST);
      dack_due   = need_ack && (dack_cnt >= DACK_LAST);
      app_accept = app_tx_valid && app_tx_ready;
      data_flags = (need_ack || ack_req || rx_psh) ? (FL_PSH | FL_ACK) : FL_PSH;
      to_act     = (retry == RETRY_MAX) ? A_GIVEUP : A_RETX;

      act = A_NONE;
      if (rx_rst && state != CLOSED) begin
         act = A_ABORT;
      end else begin
         case (state)
            CLOSED:
               if (open_req && free) act = A_OPEN;
            SYN_SENT:
               if (rx_synack)             act = A_EST;
               else if (rto_due && free)  act = to_act;
            ESTABLISHED:
               // an ACK arriving together with the timeout wins over the retransmit
               if (rto_due && free && !rx_ack_ok)           act = to_act;
               else if (app_accept)                         act = A_DATA;
               else if (close_lat && !outstanding && free)  act = A_FIN;
               else if ((ack_req || dack_due) && free)      act = A_ACK;
            FIN_WAIT:
               if (rx_ack_ok && outstanding)  act = A_FIN_DONE;
               else if (rto_due && free)      act = to_act;
            default: act = A_NONE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= CLOSED;
         snd_nxt      <= SEQ_W'(ISN);
         outstanding  <= 1'b0;
         last_flags   <= '0;
         last_seq     <= '0;
         rto_cnt      <= '0;
         retry        <= '0;
         need_ack     <= 1'b0;
         dack_cnt     <= '0;
         ack_req      <= 1'b0;
         close_lat    <= 1'b0;
         seg_tx_valid <= 1'b0;
         seg_tx_flags <= '0;
         seg_tx_seq   <= '0;
         conn_err     <= 1'b0;
         rx_deliver   <= 1'b0;
      end else begin
         rx_deliver <= rx_psh;
         conn_err   <= 1'b0;

         if (seg_tx_valid && seg_tx_ready) begin
            seg_tx_valid <= 1'b0;
            seg_tx_flags <= '0;
            seg_tx_seq   <= '0;
         end
         if (outstanding && rto_cnt != RTO_MAX) rto_cnt  <= rto_cnt + 1'b1;
         if (need_ack && dack_cnt != DACK_MAX)  dack_cnt <= dack_cnt + 1'b1;
         if (rx_psh) begin
            need_ack <= 1'b1;
            dack_cnt <= '0;
         end
         if (state == ESTABLISHED && close_req) close_lat <= 1'b1;
         if (state == ESTABLISHED && rx_ack_ok && outstanding) begin
            outstanding <= 1'b0;
            retry       <= '0;
            rto_cnt     <= '0;
         end

         case (act)
            A_ABORT: begin
               state        <= CLOSED;
               seg_tx_valid <= 1'b0;
               seg_tx_flags <= '0;
               seg_tx_seq   <= '0;
               outstanding  <= 1'b0;
               rto_cnt      <= '0;
               retry        <= '0;
               need_ack     <= 1'b0;
               dack_cnt     <= '0;
               ack_req      <= 1'b0;
               close_lat    <= 1'b0;
               conn_err     <= 1'b1;
            end
            A_OPEN: begin
               seg_tx_valid <= 1'b1;
               seg_tx_flags <= FL_SYN;
               seg_tx_seq   <= SEQ_W'(ISN);
               last_flags   <= FL_SYN;
               last_seq     <= SEQ_W'(ISN);
               snd_nxt      <= SEQ_W'(ISN) + 1'b1;
               outstanding  <= 1'b1;
               rto_cnt      <= '0;
               retry        <= '0;
               need_ack     <= 1'b0;
               dack_cnt     <= '0;
               ack_req      <= 1'b0;
               close_lat    <= 1'b0;
               state        <= SYN_SENT;
            end
            A_EST: begin
               state       <= ESTABLISHED;
               outstanding <= 1'b0;
               retry       <= '0;
               rto_cnt     <= '0;
               if (free) begin
                  seg_tx_valid <= 1'b1;
                  seg_tx_flags <= FL_ACK;
                  seg_tx_seq   <= snd_nxt;
               end else begin
                  ack_req <= 1'b1;
               end
            end
            A_RETX: begin
               seg_tx_valid <= 1'b1;
               seg_tx_flags <= last_flags;
               seg_tx_seq   <= last_seq;
               retry        <= retry + 1'b1;
               rto_cnt      <= '0;
            end
            A_GIVEUP: begin
               seg_tx_valid <= 1'b1;
               seg_tx_flags <= FL_RST;
               seg_tx_seq   <= snd_nxt;
               state        <= CLOSED;
               outstanding  <= 1'b0;
               rto_cnt      <= '0;
               retry        <= '0;
               need_ack     <= 1'b0;
               dack_cnt     <= '0;
               ack_req      <= 1'b0;
               close_lat    <= 1'b0;
               conn_err     <= 1'b1;
            end
            A_DATA: begin
               seg_tx_valid <= 1'b1;
               seg_tx_flags <= data_flags;
               seg_tx_seq   <= snd_nxt;
               last_flags   <= data_flags;
               last_seq     <= snd_nxt;
               snd_nxt      <= snd_nxt + SEQ_W'(PAYLOAD_LEN);
               outstanding  <= 1'b1;
               rto_cnt      <= '0;
               retry        <= '0;
               need_ack     <= 1'b0;
               dack_cnt     <= '0;
               ack_req      <= 1'b0;
            end
            A_FIN: begin
               seg_tx_valid <= 1'b1;
               seg_tx_flags <= FL_FIN | FL_ACK;
               seg_tx_seq   <= snd_nxt;
               last_flags   <= FL_FIN | FL_ACK;
               last_seq     <= snd_nxt;
               snd_nxt      <= snd_nxt + 1'b1;
               outstanding  <= 1'b1;
               rto_cnt      <= '0;
               retry        <= '0;
               need_ack     <= 1'b0;
               dack_cnt     <= '0;
               ack_req      <= 1'b0;
               close_lat    <= 1'b0;
               state        <= FIN_WAIT;
            end
            A_ACK: begin
               seg_tx_valid <= 1'b1;
               seg_tx_flags <= FL_ACK;
               seg_tx_seq   <= snd_nxt;
               // payload arriving this very cycle still needs its own ACK
               need_ack     <= rx_psh;
               dack_cnt     <= '0;
               ack_req      <= 1'b0;
            end
            A_FIN_DONE: begin
               state       <= CLOSED;
               outstanding <= 1'b0;
               retry       <= '0;
               rto_cnt     <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_tcp_conn_ctrl.sv
module tb_tcp_conn_ctrl;

   localparam logic [5:0] FIN = 6'h01, SYN = 6'h02, RST = 6'h04, PSH = 6'h08, ACK = 6'h10;

   logic        clk = 1'b0;
   logic        rst;
   logic        open_req, close_req, app_tx_valid, app_tx_ready;
   logic        rx_seg_valid;
   logic [5:0]  rx_flags;
   logic [31:0] rx_ack_num;
   logic        seg_tx_valid, seg_tx_ready;
   logic [5:0]  seg_tx_flags;
   logic [31:0] seg_tx_seq;
   logic [1:0]  state_o;
   logic        conn_up, conn_err, rx_deliver;

   typedef struct packed {
      logic [5:0]  f;
      logic [31:0] s;
   } seg_t;

   seg_t exp_q[$];
   int   tx_cyc[$];
   int   total = 0;
   int   bad   = 0;
   int   n_tx  = 0;
   int   n_err = 0;
   int   cyc   = 0;

   tcp_conn_ctrl #(
      .PAYLOAD_LEN(262), .SEQ_W(32), .ISN(0),
      .DELAY_ACK_CYCLES(8), .RTO_CYCLES(16), .MAX_RETRY(2)
   ) dut (
      .clk(clk), .rst(rst), .open_req(open_req), .close_req(close_req),
      .app_tx_valid(app_tx_valid), .app_tx_ready(app_tx_ready),
      .rx_seg_valid(rx_seg_valid), .rx_flags(rx_flags), .rx_ack_num(rx_ack_num),
      .seg_tx_valid(seg_tx_valid), .seg_tx_ready(seg_tx_ready),
      .seg_tx_flags(seg_tx_flags), .seg_tx_seq(seg_tx_seq),
      .state_o(state_o), .conn_up(conn_up), .conn_err(conn_err), .rx_deliver(rx_deliver)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // scoreboard: every handed-off segment is checked against the queue head
   always @(negedge clk) begin
      if (!rst && conn_err) n_err++;
      if (!rst && seg_tx_valid && seg_tx_ready) begin
         n_tx++;
         tx_cyc.push_back(cyc);
         total++;
         assert (exp_q.size() != 0) else begin
            bad++;
            $error("FAIL seg_unexpected observed flags=%0h seq=%0d expected=none", seg_tx_flags, seg_tx_seq);
         end
         if (exp_q.size() != 0) begin
            seg_t e;
            e = exp_q.pop_front();
            total++;
            assert ({seg_tx_flags, seg_tx_seq} === e) else begin
               bad++;
               $error("FAIL seg_content observed flags=%0h seq=%0d expected flags=%0h seq=%0d",
                      seg_tx_flags, seg_tx_seq, e.f, e.s);
            end
         end
      end
   end

   function automatic seg_t mk(input logic [5:0] f, input logic [31:0] s);
      seg_t r;
      r.f = f;
      r.s = s;
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      chk("queue_drain", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic rx(input logic [5:0] f, input logic [31:0] a);
      rx_seg_valid = 1'b1;
      rx_flags     = f;
      rx_ack_num   = a;
      tick();
      rx_seg_valid = 1'b0;
      rx_flags     = '0;
      rx_ack_num   = '0;
   endtask

   initial begin
      int n, n0, e0, base;
      rst = 1'b1;
      open_req = 0; close_req = 0; app_tx_valid = 0;
      rx_seg_valid = 0; rx_flags = '0; rx_ack_num = '0;
      seg_tx_ready = 1'b1;
      repeat (3) tick();
      chk("rst_state",   64'(state_o), 64'd0);
      chk("rst_conn_up", 64'(conn_up), 64'd0);
      chk("rst_seg",     64'({seg_tx_valid, seg_tx_flags, seg_tx_seq}), 64'd0);
      chk("rst_misc",    64'({app_tx_ready, conn_err, rx_deliver}), 64'd0);
      rst = 1'b0;
      tick();

      // open handshake
      exp_q.push_back(mk(SYN, 32'd0));
      open_req = 1'b1;
      tick();
      open_req = 1'b0;
      chk("syn_sent_state", 64'(state_o), 64'd1);
      exp_q.push_back(mk(ACK, 32'd1));
      rx(SYN | ACK, 32'd1);
      chk("est_state", 64'(state_o), 64'd2);
      chk("est_conn_up", 64'(conn_up), 64'd1);
      drain(10);
      chk("est_app_ready", 64'(app_tx_ready), 64'd1);

      // delayed ACK after received payload
      rx(PSH, 32'd0);
      chk("deliver_pulse", 64'(rx_deliver), 64'd1);
      exp_q.push_back(mk(ACK, 32'd1));
      n = 0;
      tick();
      n++;
      chk("deliver_one_cycle", 64'(rx_deliver), 64'd0);
      while (!seg_tx_valid && n < 30) begin
         tick();
         n++;
      end
      chk("dack_delay", 64'(n), 64'd8);
      drain(5);

      // piggy-backed ACK on data
      rx(PSH, 32'd0);
      tick();
      tick();
      exp_q.push_back(mk(PSH | ACK, 32'd1));
      app_tx_valid = 1'b1;
      tick();
      app_tx_valid = 1'b0;
      chk("data_ready_drops", 64'(app_tx_ready), 64'd0);
      drain(5);
      n0 = n_tx;
      rx(ACK, 32'd5);
      chk("bad_ack_ignored", 64'(app_tx_ready), 64'd0);
      rx(ACK, 32'd263);
      chk("good_ack_clears", 64'(app_tx_ready), 64'd1);
      repeat (25) tick();
      chk("no_extra_seg", 64'(n_tx), 64'(n0));

      // back-pressure: request held stable
      seg_tx_ready = 1'b0;
      exp_q.push_back(mk(PSH, 32'd263));
      app_tx_valid = 1'b1;
      tick();
      app_tx_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("hold_stable", 64'({seg_tx_valid, seg_tx_flags, seg_tx_seq}), {25'd0, 1'b1, PSH, 32'd263});
         tick();
      end
      seg_tx_ready = 1'b1;
      drain(5);
      rx(ACK, 32'd525);
      chk("ack2_clears", 64'(app_tx_ready), 64'd1);

      // close
      exp_q.push_back(mk(FIN | ACK, 32'd525));
      close_req = 1'b1;
      tick();
      close_req = 1'b0;
      drain(5);
      chk("fin_wait_state", 64'(state_o), 64'd3);
      chk("fin_wait_ready", 64'(app_tx_ready), 64'd0);
      rx(ACK, 32'd526);
      chk("closed_state", 64'(state_o), 64'd0);

      // retransmit timeouts then give-up
      base = tx_cyc.size();
      for (int i = 0; i < 3; i++) exp_q.push_back(mk(SYN, 32'd0));
      exp_q.push_back(mk(RST, 32'd1));
      open_req = 1'b1;
      tick();
      open_req = 1'b0;
      n = 0;
      while (!conn_err && n < 80) begin
         tick();
         n++;
      end
      chk("rto_err_pulse", 64'(conn_err), 64'd1);
      chk("rto_closed", 64'(state_o), 64'd0);
      tick();
      chk("rto_err_one_cycle", 64'(conn_err), 64'd0);
      drain(5);
      chk("rto_seg_count", 64'(tx_cyc.size() - base), 64'd4);
      for (int i = 1; i < 4; i++)
         if (tx_cyc.size() >= base + 4)
            chk("rto_period", 64'(tx_cyc[base + i] - tx_cyc[base + i - 1]), 64'd16);

      // peer RST while established
      exp_q.push_back(mk(SYN, 32'd0));
      open_req = 1'b1;
      tick();
      open_req = 1'b0;
      exp_q.push_back(mk(ACK, 32'd1));
      rx(SYN | ACK, 32'd1);
      drain(5);
      chk("reopen_est", 64'(state_o), 64'd2);
      n0 = n_tx;
      rx(RST, 32'd0);
      chk("peer_rst_err", 64'(conn_err), 64'd1);
      chk("peer_rst_state", 64'(state_o), 64'd0);
      tick();
      chk("peer_rst_outputs",
          64'({seg_tx_valid, seg_tx_flags, seg_tx_seq, app_tx_ready, conn_up, conn_err, rx_deliver, state_o}),
          64'd0);
      repeat (40) tick();
      chk("peer_rst_quiet", 64'(n_tx), 64'(n0));

      // reset in the middle of the handshake
      seg_tx_ready = 1'b0;
      open_req = 1'b1;
      tick();
      open_req = 1'b0;
      tick();
      chk("mid_hs_state", 64'({state_o, seg_tx_valid}), 64'({2'd1, 1'b1}));
      rst = 1'b1;
      #1;
      chk("async_rst", 64'({state_o, seg_tx_valid, seg_tx_flags}), 64'd0);
      tick();
      rst = 1'b0;
      seg_tx_ready = 1'b1;
      n0 = n_tx;
      e0 = n_err;
      repeat (40) tick();
      chk("post_rst_no_seg", 64'(n_tx), 64'(n0));
      chk("post_rst_no_err", 64'(n_err), 64'(e0));
      chk("post_rst_outputs",
          64'({seg_tx_valid, seg_tx_flags, seg_tx_seq, app_tx_ready, conn_up, conn_err, rx_deliver, state_o}),
          64'd0);
      chk("queue_empty_end", 64'(exp_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tcp_conn_ctrl.md
TCP_CONN_CTRL -- requirements
Module: tcp_conn_ctrl

Interface
REQ-001 Parameters SHALL be: PAYLOAD_LEN, default 262, payload bytes per data segment; SEQ_W, default 32, sequence-number width; ISN, default 0, initial send sequence; DELAY_ACK_CYCLES, default 1000000, delayed-ACK timeout; RTO_CYCLES, default 4000000, retransmit timeout; MAX_RETRY, default 3, retransmissions before abort.
REQ-002 One clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 open_req / close_req  input  1 each  single-cycle connection open / close requests.
REQ-006 app_tx_valid  input  1; app_tx_ready  output  1  application data-segment handshake.
REQ-007 rx_seg_valid  input  1; rx_flags  input  6; rx_ack_num  input  SEQ_W  received segment strobe, flags, acknowledgement number.
REQ-008 seg_tx_valid  output  1; seg_tx_ready  input  1; seg_tx_flags  output  6; seg_tx_seq  output  SEQ_W  outgoing segment request to TCP builder.
REQ-009 state_o  output  2; conn_up  output  1; conn_err  output  1; rx_deliver  output  1  status, error pulse, received-payload pulse.
REQ-010 Flag bits SHALL be FIN=bit0, SYN=bit1, RST=bit2, PSH=bit3, ACK=bit4, URG=bit5.

Function
REQ-011 States SHALL be CLOSED=0, SYN_SENT=1, ESTABLISHED=2, FIN_WAIT=3, driven on state_o; conn_up = (state==ESTABLISHED).
REQ-012 Outgoing handshake: segment transfers on seg_tx_valid & seg_tx_ready; flags/seq SHALL stay stable while valid & !ready; at most one pending request.
REQ-013 Stop-and-wait: at most one unacknowledged segment (SYN, data or FIN); snd_nxt advances by 1 for SYN/FIN, PAYLOAD_LEN for data, modulo 2^SEQ_W.
REQ-014 CLOSED + open_req: issue SYN, seq=ISN, go SYN_SENT; open_req ignored in other states.
REQ-015 SYN_SENT + rx SYN|ACK with rx_ack_num==snd_nxt: issue pure ACK, go ESTABLISHED; other segments ignored.
REQ-016 app_tx_ready SHALL be 1 only in ESTABLISHED with no outstanding segment, no pending request, no latched close.
REQ-017 Accepted app segment: flags PSH, or PSH|ACK if need_ack set (piggy-back clears need_ack and delay counter).
REQ-018 rx segment with PSH in ESTABLISHED: pulse rx_deliver one cycle later, set need_ack, restart delay counter.
REQ-019 need_ack set and counter reaching DELAY_ACK_CYCLES with nothing pending: issue pure ACK, clear need_ack and counter.
REQ-020 rx ACK with rx_ack_num==snd_nxt clears outstanding and retry count; mismatched ACK ignored.
REQ-021 Same-cycle rx PSH and app acceptance: data segment carries PSH|ACK; need_ack clear afterwards.
REQ-022 close_req in ESTABLISHED is latched; once outstanding clear, issue FIN|ACK and go FIN_WAIT; ACK of FIN -> CLOSED.
REQ-023 Retransmit timer runs while a segment is outstanding; at RTO_CYCLES reissue identical flags/seq, increment retry, restart timer.
REQ-024 Timeout with retry==MAX_RETRY: issue RST, go CLOSED, pulse conn_err one cycle.
REQ-025 rx RST in any non-CLOSED state: go CLOSED immediately, drop pending request, pulse conn_err.
REQ-026 Counters SHALL saturate, never wrap; width sized by $clog2 of respective parameter.

Reset
REQ-027 On rst: state CLOSED, snd_nxt=ISN, counters, retry, need_ack, close latch cleared; all outputs 0 (seg_tx_flags=0, seg_tx_seq=0).
REQ-028 rst mid-transfer SHALL abort immediately, no segment or pulse issued after release until new open_req.

Verification
REQ-029 open_req, ready=1, reply SYN|ACK ack=1 -> SYN seq=0, ACK seq=1, state_o=2, conn_up=1.
REQ-030 Established, rx PSH, no app data, DELAY_ACK_CYCLES=8 -> rx_deliver pulse, pure ACK after 8 cycles.
REQ-031 Established, rx PSH then app_tx_valid within 8 cycles -> one PSH|ACK seq=1, no separate ACK; ACK ack=263 clears outstanding.
REQ-032 No SYN|ACK, RTO_CYCLES=16, MAX_RETRY=2 -> SYN at 0,16,32, RST at 48, conn_err pulse, state_o=0.
REQ-033 seg_tx_ready low 5 cycles -> seg_tx_valid, flags, seq held stable throughout.
REQ-034 rx RST in ESTABLISHED, and rst asserted mid-handshake -> state_o=0, all outputs 0, no further segments.
